// File: rtl/s_term_cfg_pkg.sv
// rtl/s_term_cfg_pkg.sv - select codes, types and helpers for the south-terminal configurable switch matrix
package s_term_cfg_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_STRAIGHT = 2'b00;
  localparam sel_t SEL_NEIGH    = 2'b01;
  localparam sel_t SEL_ZERO     = 2'b10;
  localparam sel_t SEL_ONE      = 2'b11;

  function automatic int cfg_len(input int nch);
    return 2 * nch;
  endfunction

endpackage

// File: rtl/s_term_cfg_chain.sv
// rtl/s_term_cfg_chain.sv - serial config shift chain with length-checked commit into the active select register
module s_term_cfg_chain
  import s_term_cfg_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_shift,
  input  logic                      cfg_in,
  input  logic                      cfg_commit,
  output logic                      cfg_out,
  output logic                      cfg_ok,
  output logic                      cfg_err,
  output logic [cfg_len(NCH)-1:0]   active
);

  localparam int CFG_LEN = cfg_len(NCH);
  localparam int CW      = $clog2(CFG_LEN + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

  logic [CFG_LEN-1:0] chain_q, chain_d;
  logic [CFG_LEN-1:0] active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               accept;

  // A commit is only honoured when exactly CFG_LEN bits arrived and no shift is in flight.
  assign accept = cfg_commit && !cfg_shift && (cnt_q == CNT_FULL);

  always_comb begin
    chain_d  = chain_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    ok_d     = accept;
    err_d    = cfg_commit && !accept;

    if (cfg_shift) begin
      chain_d = {chain_q[CFG_LEN-2:0], cfg_in};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (cfg_commit) begin
      cnt_d = '0;
    end

    if (accept) begin
      active_d = chain_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q  <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  assign cfg_out = chain_q[CFG_LEN-1];
  assign cfg_ok  = ok_q;
  assign cfg_err = err_q;
  assign active  = active_q;

endmodule

// File: rtl/s_term_cfg_switch_matrix.sv
// rtl/s_term_cfg_switch_matrix.sv - per-channel 4:1 south-to-north switch; S_TERM_CFG_SWITCH_MATRIX_OUT_REG_EN registers to_N
module s_term_cfg_switch_matrix
  import s_term_cfg_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic           UserCLK,
  input  logic           RST,
  input  logic           ConfigShift,
  input  logic           ConfigIn,
  output logic           ConfigOut,
  input  logic           ConfigCommit,
  output logic           cfg_ok,
  output logic           cfg_err,
  input  logic [NCH-1:0] from_S,
  output logic [NCH-1:0] to_N
);

  localparam int CFG_LEN = cfg_len(NCH);

  logic [CFG_LEN-1:0] active;
  logic [NCH-1:0]     mux_out;

  s_term_cfg_chain #(
    .NCH(NCH)
  ) u_chain (
    .clk       (UserCLK),
    .rst       (RST),
    .cfg_shift (ConfigShift),
    .cfg_in    (ConfigIn),
    .cfg_commit(ConfigCommit),
    .cfg_out   (ConfigOut),
    .cfg_ok    (cfg_ok),
    .cfg_err   (cfg_err),
    .active    (active)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam int NB = (gi + 1) % NCH;
    sel_t sel;
    assign sel = active[2*gi +: 2];

    always_comb begin
      mux_out[gi] = from_S[gi];
      case (sel)
        SEL_STRAIGHT: mux_out[gi] = from_S[gi];
        SEL_NEIGH:    mux_out[gi] = from_S[NB];
        SEL_ZERO:     mux_out[gi] = 1'b0;
        SEL_ONE:      mux_out[gi] = 1'b1;
        default:      mux_out[gi] = from_S[gi];
      endcase
    end
  end

`ifdef S_TERM_CFG_SWITCH_MATRIX_OUT_REG_EN
  logic [NCH-1:0] to_n_q, to_n_d;

  always_comb begin
    to_n_d = mux_out;
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      to_n_q <= '0;
    end else begin
      to_n_q <= to_n_d;
    end
  end

  assign to_N = to_n_q;
`else
  assign to_N = mux_out;
`endif

endmodule

// File: tb/tb_s_term_cfg_switch_matrix.sv
// tb/tb_s_term_cfg_switch_matrix.sv - directed self-checking bench for s_term_cfg_switch_matrix
module tb_s_term_cfg_switch_matrix;

  logic       UserCLK = 1'b0;
  logic       RST;
  logic       ConfigShift;
  logic       ConfigIn;
  logic       ConfigOut;
  logic       ConfigCommit;
  logic       cfg_ok;
  logic       cfg_err;
  logic [7:0] from_S;
  logic [7:0] to_N;

  int n_checks = 0;
  int n_fail   = 0;

  s_term_cfg_switch_matrix #(.NCH(8)) dut (
    .UserCLK     (UserCLK),
    .RST         (RST),
    .ConfigShift (ConfigShift),
    .ConfigIn    (ConfigIn),
    .ConfigOut   (ConfigOut),
    .ConfigCommit(ConfigCommit),
    .cfg_ok      (cfg_ok),
    .cfg_err     (cfg_err),
    .from_S      (from_S),
    .to_N        (to_N)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Bits go in MSB first so w[n-1] ends up deepest in the chain.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ConfigShift = 1'b1;
      ConfigIn    = w[i];
      tick();
    end
    ConfigShift = 1'b0;
    ConfigIn    = 1'b0;
  endtask

  task automatic commit();
    ConfigCommit = 1'b1;
    tick();
    ConfigCommit = 1'b0;
  endtask

  task automatic check_route(input string tag, input logic [7:0] s, input logic [7:0] exp);
    from_S = s;
    tick();
    check_eq(tag, 32'(to_N), 32'(exp));
  endtask

  initial begin
    RST          = 1'b1;
    ConfigShift  = 1'b0;
    ConfigIn     = 1'b0;
    ConfigCommit = 1'b0;
    from_S       = 8'hA5;
    #2;
`ifdef S_TERM_CFG_SWITCH_MATRIX_OUT_REG_EN
    check_eq("reset_to_n", 32'(to_N), 'h00);
`else
    check_eq("reset_to_n", 32'(to_N), 'hA5);
`endif
    check_eq("reset_cfg_out", 32'(ConfigOut), 0);
    check_eq("reset_ok", 32'(cfg_ok), 0);
    check_eq("reset_err", 32'(cfg_err), 0);
    tick();
    RST = 1'b0;
    check_route("post_reset_pass", 8'hA5, 8'hA5);

    // Full load: ch7..4 constant one, ch3..0 constant zero
    shift_bits('hFFAA, 16);
    check_eq("full_cfg_out", 32'(ConfigOut), 1);
    commit();
    check_eq("full_ok", 32'(cfg_ok), 1);
    check_eq("full_err", 32'(cfg_err), 0);
    tick();
    check_eq("full_ok_drop", 32'(cfg_ok), 0);
    check_route("full_route_00", 8'h00, 8'hF0);
    check_route("full_route_ff", 8'hFF, 8'hF0);

    // Back-to-back commit sees a cleared counter
    commit();
    check_eq("b2b_err", 32'(cfg_err), 1);
    check_eq("b2b_ok", 32'(cfg_ok), 0);
    check_route("b2b_route", 8'h3C, 8'hF0);

    // Neighbour routing rotates right by one
    shift_bits('h5555, 16);
    commit();
    check_eq("neigh_ok", 32'(cfg_ok), 1);
    check_route("neigh_01", 8'h01, 8'h80);
    check_route("neigh_80", 8'h80, 8'h40);

    shift_bits('h0000, 15);
    commit();
    check_eq("short_err", 32'(cfg_err), 1);
    check_eq("short_ok", 32'(cfg_ok), 0);
    check_route("short_route", 8'h01, 8'h80);

    shift_bits('h00000, 17);
    commit();
    check_eq("long_err", 32'(cfg_err), 1);
    check_route("long_route", 8'h01, 8'h80);

    // Shift and commit in the same cycle: rejected but the chain still moves
    shift_bits('h7FFF, 15);
    ConfigShift  = 1'b1;
    ConfigIn     = 1'b0;
    ConfigCommit = 1'b1;
    tick();
    ConfigShift  = 1'b0;
    ConfigCommit = 1'b0;
    check_eq("simul_err", 32'(cfg_err), 1);
    check_eq("simul_ok", 32'(cfg_ok), 0);
    check_eq("simul_chain_msb", 32'(ConfigOut), 1);
    commit();
    check_eq("simul_cnt_cleared", 32'(cfg_err), 1);
    check_route("simul_route", 8'h01, 8'h80);
    shift_bits('h0000, 16);
    commit();
    check_eq("reload_ok", 32'(cfg_ok), 1);
    check_route("reload_route", 8'h3C, 8'h3C);

    // Reset in the middle of a load
    shift_bits('hFFAA, 16);
    commit();
    check_eq("pre_rst_ok", 32'(cfg_ok), 1);
    check_route("pre_rst_route", 8'h3C, 8'hF0);
    shift_bits('hFF, 8);
    #3;
    RST = 1'b1;
    #1;
    check_eq("midrst_cfg_out", 32'(ConfigOut), 0);
`ifdef S_TERM_CFG_SWITCH_MATRIX_OUT_REG_EN
    check_eq("midrst_to_n", 32'(to_N), 'h00);
`else
    check_eq("midrst_to_n", 32'(to_N), 'h3C);
`endif
    tick();
    RST = 1'b0;
    shift_bits('hE4E4, 16);
    commit();
    check_eq("midrst_ok", 32'(cfg_ok), 1);
    check_eq("midrst_err", 32'(cfg_err), 0);
    check_route("midrst_route_55", 8'h55, 8'hBB);
    check_route("midrst_route_aa", 8'hAA, 8'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
